// File: rtl/pid_gain_regbank_pkg.sv
// Shared constants and types for the PID gain register bank.
// CTRL/STATUS bit positions and the commit FSM state encoding.
package pid_regbank_pkg;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_REVERT = 1;

    localparam int ST_ARMED   = 0;
    localparam int ST_PENDING = 1;
    localparam int ST_ERR     = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } commit_state_e;

endpackage

// File: rtl/pid_gain_regbank_slot.sv
// One shadow/active gain register pair.
// Apply copies shadow into active; revert copies active back into shadow.
module pid_gain_slot #(
    parameter int DATA_W      = 6,
    parameter int RESET_VALUE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              apply_i,
    input  logic              revert_i,
    output logic [DATA_W-1:0] shadow_o,
    output logic [DATA_W-1:0] active_o
);

    logic [DATA_W-1:0] shadow_q;
    logic [DATA_W-1:0] active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= DATA_W'(RESET_VALUE);
            active_q <= DATA_W'(RESET_VALUE);
        end else begin
            // apply samples the pre-edge shadow; a same-cycle write only lands in shadow
            if (apply_i) active_q <= shadow_q;
            if (revert_i) shadow_q <= active_q;
            else if (we_i) shadow_q <= wdata_i;
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;

endmodule

// File: rtl/pid_gain_regbank.sv
// Double-buffered PID gain register bank with auto-increment pointer,
// frame-synchronous commit, revert and sticky address-error status.
module pid_gain_regbank
    import pid_regbank_pkg::*;
#(
    parameter int NUM_REGS    = 3,
    parameter int DATA_W      = 6,
    parameter int ADDR_W      = 8,
    parameter int RESET_VALUE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       addr_load,
    input  logic [ADDR_W-1:0]          addr_in,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       frame_strobe,
    output logic [NUM_REGS*DATA_W-1:0] gains,
    output logic                       commit_armed,
    output logic                       pending,
    output logic                       addr_err
);

    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(NUM_REGS);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] eff;
    logic              is_gain, is_ctrl, is_oob;
    logic              wr_gain, wr_ctrl, do_rd, access;
    logic              revert, commit, apply;
    logic              pending_q, pending_d;
    logic              err_q, err_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, shadow_sel, status_w;
    commit_state_e     state_q;

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];

    assign eff     = addr_load ? addr_in : ptr_q;
    assign is_gain = eff < CTRL_A;
    assign is_ctrl = eff == CTRL_A;
    assign is_oob  = eff > CTRL_A;
    assign wr_gain = wr_en & is_gain;
    assign wr_ctrl = wr_en & is_ctrl;
    assign do_rd   = rd_en & ~wr_en;
    assign access  = wr_en | rd_en;

    assign revert = wr_ctrl & wr_data[CTRL_REVERT];
    assign commit = wr_ctrl & wr_data[CTRL_COMMIT] & ~revert;
    assign apply  = (state_q == ARMED) & frame_strobe & ~revert;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_slot
        pid_gain_slot #(
            .DATA_W      (DATA_W),
            .RESET_VALUE (RESET_VALUE)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .we_i     (wr_gain && (eff == ADDR_W'(k))),
            .wdata_i  (wr_data),
            .apply_i  (apply),
            .revert_i (revert),
            .shadow_o (shadow[k]),
            .active_o (active[k])
        );
        assign gains[k*DATA_W +: DATA_W] = active[k];
    end

    always_comb begin
        shadow_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (eff == ADDR_W'(k)) shadow_sel = shadow[k];
        end
    end

    assign status_w = DATA_W'({err_q, pending_q, state_q == ARMED});

    always_comb begin
        rd_data_d = rd_data_q;
        if (do_rd) begin
            if (is_gain) rd_data_d = shadow_sel;
            else if (is_ctrl) rd_data_d = status_w;
            else rd_data_d = '0;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (apply || revert) pending_d = 1'b0;
        if (wr_gain) pending_d = 1'b1;
    end

    // out-of-range set wins over a same-cycle STATUS-read clear
    always_comb begin
        err_d = err_q;
        if (do_rd && is_ctrl) err_d = 1'b0;
        if (access && is_oob) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (commit) state_q <= ARMED;
                end
                ARMED: begin
                    if (revert) state_q <= IDLE;
                    else if (commit) state_q <= ARMED;
                    else if (frame_strobe) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (access) ptr_q <= (eff >= CTRL_A) ? '0 : eff + ADDR_W'(1);
            else if (addr_load) ptr_q <= addr_in;
            pending_q  <= pending_d;
            err_q      <= err_d;
            rd_valid_q <= do_rd;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign commit_armed = (state_q == ARMED);
    assign pending      = pending_q;
    assign addr_err     = err_q;

endmodule

// File: tb/tb_pid_gain_regbank.sv
// Scoreboard bench for pid_gain_regbank: reads push expected data,
// a negedge monitor pops and compares on every rd_valid.
module tb_pid_gain_regbank;

    localparam int NR = 3;
    localparam int DW = 6;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            addr_load;
    logic [AW-1:0]   addr_in;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            rd_en;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            frame_strobe;
    logic [NR*DW-1:0] gains;
    logic            commit_armed;
    logic            pending;
    logic            addr_err;

    int total = 0;
    int passed = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    pid_gain_regbank #(
        .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .RESET_VALUE(0)
    ) dut (
        .clk(clk), .rst(rst), .addr_load(addr_load), .addr_in(addr_in),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .frame_strobe(frame_strobe), .gains(gains),
        .commit_armed(commit_armed), .pending(pending), .addr_err(addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_unexpected: got rd_valid data %0d expected no read", rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data === e) passed++;
                else $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        addr_load = 1'b0; wr_en = 1'b0; rd_en = 1'b0; frame_strobe = 1'b0;
    endtask

    task automatic wr(input logic ld, input int a, input int d);
        addr_load = ld; addr_in = AW'(a); wr_en = 1'b1; wr_data = DW'(d);
        step();
    endtask

    task automatic rd(input logic ld, input int a, input int e);
        addr_load = ld; addr_in = AW'(a); rd_en = 1'b1;
        exp_q.push_back(DW'(e));
        step();
    endtask

    task automatic strobe();
        frame_strobe = 1'b1;
        step();
    endtask

    localparam logic [NR*DW-1:0] G1 = {6'd12, 6'd9, 6'd5};

    initial begin
        rst = 1'b1; addr_load = 1'b0; addr_in = '0; wr_en = 1'b0;
        wr_data = '0; rd_en = 1'b0; frame_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_gains", 32'(gains), 0);
        chk("rst_flags", {commit_armed, pending, addr_err}, 0);
        chk("rst_rd", {rd_valid, rd_data}, 0);

        rd(1'b1, 0, 0); rd(1'b0, 1, 0); rd(1'b0, 2, 0); rd(1'b0, 3, 0);

        wr(1'b1, 0, 5); wr(1'b0, 1, 9); wr(1'b0, 2, 12);
        chk("pend_after_wr", pending, 1);
        chk("gains_before_commit", 32'(gains), 0);
        wr(1'b0, 3, 1);
        chk("armed", commit_armed, 1);
        chk("gains_armed_no_strobe", 32'(gains), 0);
        strobe();
        chk("gains_applied", 32'(gains), 32'(G1));
        chk("flags_after_apply", {commit_armed, pending}, 0);
        rd(1'b0, 0, 5); rd(1'b0, 1, 9); rd(1'b0, 2, 12);

        wr(1'b1, 3, 1);
        addr_load = 1'b1; addr_in = 8'd1; wr_en = 1'b1; wr_data = 6'd63;
        frame_strobe = 1'b1;
        step();
        chk("gains_sameclk_wr", 32'(gains), 32'(G1));
        chk("pend_sameclk_wr", pending, 1);
        chk("armed_cleared", commit_armed, 0);
        rd(1'b1, 1, 63);

        wr(1'b1, 0, 7); wr(1'b1, 3, 3);
        chk("revert_flags", {commit_armed, pending}, 0);
        rd(1'b1, 0, 5); rd(1'b0, 1, 9);
        strobe();
        chk("gains_after_revert", 32'(gains), 32'(G1));

        wr(1'b1, 200, 1);
        chk("err_set", addr_err, 1);
        chk("gains_oob_wr", 32'(gains), 32'(G1));
        rd(1'b1, 3, 4);
        rd(1'b1, 3, 0);
        chk("err_cleared", addr_err, 0);
        rd(1'b1, 4, 0);
        chk("err_oob_rd", addr_err, 1);
        rd(1'b1, 3, 4);

        addr_load = 1'b1; addr_in = 8'd0; wr_en = 1'b1; rd_en = 1'b1;
        wr_data = 6'd20;
        step();
        rd(1'b1, 0, 20);

        wr(1'b1, 3, 1);
        chk("armed_pre_rst", commit_armed, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gains", 32'(gains), 0);
        chk("async_rst_flags", {commit_armed, pending, addr_err}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        strobe();
        chk("gains_after_rst_strobe", 32'(gains), 0);
        rd(1'b1, 0, 0);

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
